cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter PC_STEP, default 2, PC byte increment applied on every fetch.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 run  input  1  level; 1 permits instruction fetch.
REQ-005 opcode  input  4  instruction[15:12], sampled from IR in DECODE.
REQ-006 zero  input  1  ALU zero flag, valid in EXECUTE.
REQ-007 mem_ready  input  1  data memory completes the access in the current cycle.
REQ-008 ir_write, pc_write  output  1 each  IR load strobe; PC update strobe.
REQ-009 pc_src  output  2  00 PC+PC_STEP, 01 branch target, 10 jump target.
REQ-010 alu_op  output  2  10 add (LW/SW), 01 sub (branch), 00 function taken from opcode.
REQ-011 alu_src, reg_dst, mem_to_reg  output  1 each  datapath mux selects.
REQ-012 reg_write_enable, memory_write_enable, memory_read  output  1 each  datapath strobes.
REQ-013 halted  output  1  sticky halt indication.
REQ-014 state  output  3  current FSM state encoding, for debug.

Function
REQ-015 Opcode map: 0000 LW; 0001 SW; 0010-1001 R-type ALU; 1011 BEQ; 1100 BNE; 1101 JMP; 1111 HALT; 1010, 1110 illegal, treated as NOP.
REQ-016 States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT; outputs Moore-decoded from state and latched opcode, except the branch pc_write, which also depends on zero.
REQ-017 IDLE: all strobes 0; go to FETCH when run=1.
REQ-018 FETCH: ir_write=1, pc_write=1, pc_src=00; go to DECODE.
REQ-019 DECODE: latch opcode; HALT goes to HALT; NOP returns to FETCH (IDLE if run=0); all others go to EXECUTE.
REQ-020 EXECUTE: R-type sets alu_op=00, alu_src=0, reg_dst=1 and goes to WRITEBACK; LW/SW set alu_op=10, alu_src=1 and go to MEM.
REQ-021 EXECUTE for branches sets alu_op=01; BEQ asserts pc_write with pc_src=01 iff zero=1; BNE does so iff zero=0.
REQ-022 EXECUTE for JMP asserts pc_write with pc_src=10; branches and JMP then go to FETCH (IDLE if run=0).
REQ-023 MEM: LW holds memory_read=1 and SW holds memory_write_enable=1 each cycle until mem_ready=1; the strobes drop in the cycle after mem_ready.
REQ-024 MEM exit: LW goes to WRITEBACK; SW goes to FETCH (IDLE if run=0).
REQ-025 WRITEBACK: reg_write_enable=1 for exactly one cycle; mem_to_reg=1 for LW, 0 for R-type; reg_dst=0 for LW; then go to FETCH (IDLE if run=0).
REQ-026 Cycle counts with mem_ready tied high: R-type 4, LW 5, SW 4, BEQ/BNE/JMP 3, NOP 2; each mem_ready=0 cycle adds 1 to LW/SW.
REQ-027 run=0 mid-instruction never aborts; the current instruction retires, then the FSM enters IDLE.
REQ-028 HALT state: halted=1, all strobes 0, run ignored; exit only via reset.
REQ-029 No two of ir_write, reg_write_enable, memory_write_enable are ever asserted in the same cycle.

Reset
REQ-030 rst_n=0 forces IDLE immediately, without waiting for clk, including mid-MEM or in HALT; all outputs read 0 and state reads the IDLE encoding.
REQ-031 First FETCH occurs on the first rising edge after rst_n deasserts with run=1.

Configuration
REQ-032 Macro SEQ_PERF_CNT_EN: when defined, add outputs instr_retired[15:0] and cycle_count[15:0].
REQ-033 instr_retired increments on each instruction retirement, including NOP; cycle_count increments each cycle outside IDLE and HALT; both wrap at 16'hFFFF to 0 and reset to 0.
REQ-034 Without SEQ_PERF_CNT_EN, neither port nor any counter logic exists; all other behaviour is identical.

Structure
REQ-035 Shared package cpu_pkg holds the state enum, opcode constants, alu_op codes and pc_src codes.
REQ-036 Combinational sub-module seq_decode classifies opcode into is_lw, is_sw, is_rtype, is_beq, is_bne, is_jmp, is_halt and is_nop.

Verification
REQ-037 Reset, run=1, opcode 0010, mem_ready=1 -> state sequence FETCH, DECODE, EXECUTE, WRITEBACK, FETCH; reg_write_enable=1 only in cycle 4; alu_op=00.
REQ-038 LW with mem_ready low for 3 MEM cycles -> memory_read=1 for 4 cycles; WRITEBACK follows with mem_to_reg=1; total 8 cycles.
REQ-039 BEQ with zero=1 -> pc_write=1 and pc_src=01 in EXECUTE; with zero=0 -> pc_write=0 in EXECUTE; BNE gives the inverse results.
REQ-040 Opcode 1111 -> halted=1 from the cycle after DECODE; ir_write never asserts again while run=1 for 20 cycles.
REQ-041 rst_n pulsed low mid-MEM of SW -> memory_write_enable drops without a clk edge; state=IDLE.
REQ-042 With SEQ_PERF_CNT_EN defined: 3 ADDs then run=0 -> instr_retired=3, cycle_count=12.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU sequencer: FSM state encoding,
// opcode map, ALU operation codes and PC source select codes.
package cpu_pkg;

   // FSM states; the encoding is visible on the sequencer's debug state port
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEM       = 3'd4,
      S_WRITEBACK = 3'd5,
      S_HALT      = 3'd6
   } state_t;

   // Opcode map (instruction[15:12]); 0x2..0x9 are R-type ALU operations,
   // 0xA and 0xE are illegal and retire as NOPs
   localparam logic [3:0] OP_LW       = 4'h0;
   localparam logic [3:0] OP_SW       = 4'h1;
   localparam logic [3:0] OP_RTYPE_LO = 4'h2;
   localparam logic [3:0] OP_RTYPE_HI = 4'h9;
   localparam logic [3:0] OP_BEQ      = 4'hB;
   localparam logic [3:0] OP_BNE      = 4'hC;
   localparam logic [3:0] OP_JMP      = 4'hD;
   localparam logic [3:0] OP_HALT     = 4'hF;

   // ALU operation select
   localparam logic [1:0] ALU_FUNC = 2'b00;  // function taken from opcode
   localparam logic [1:0] ALU_SUB  = 2'b01;  // branch compare
   localparam logic [1:0] ALU_ADD  = 2'b10;  // LW/SW address

   // PC source select
   localparam logic [1:0] PC_INC    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode classifier for the CPU sequencer. Exactly one class
// output is high for any opcode value.
module seq_decode
   import cpu_pkg::*;
(
   input  logic [3:0] opcode,
   output logic       is_lw,
   output logic       is_sw,
   output logic       is_rtype,
   output logic       is_beq,
   output logic       is_bne,
   output logic       is_jmp,
   output logic       is_halt,
   output logic       is_nop
);

   // classify the opcode; anything not explicitly mapped is a NOP
   always_comb begin
      is_lw    = 1'b0;
      is_sw    = 1'b0;
      is_rtype = 1'b0;
      is_beq   = 1'b0;
      is_bne   = 1'b0;
      is_jmp   = 1'b0;
      is_halt  = 1'b0;
      is_nop   = 1'b0;
      if (opcode == OP_LW)
         is_lw = 1'b1;
      else if (opcode == OP_SW)
         is_sw = 1'b1;
      else if (opcode >= OP_RTYPE_LO && opcode <= OP_RTYPE_HI)
         is_rtype = 1'b1;
      else if (opcode == OP_BEQ)
         is_beq = 1'b1;
      else if (opcode == OP_BNE)
         is_bne = 1'b1;
      else if (opcode == OP_JMP)
         is_jmp = 1'b1;
      else if (opcode == OP_HALT)
         is_halt = 1'b1;
      else
         is_nop = 1'b1;
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer (IDLE/FETCH/DECODE/EXECUTE/MEM/WRITEBACK/
// HALT). Outputs are Moore-decoded from the state and the opcode latched in
// DECODE; only the branch pc_write also looks at the ALU zero flag.
// Optional build macro SEQ_PERF_CNT_EN adds instr_retired/cycle_count ports.
//
// Memory handshake: while in MEM the LW/SW strobe (memory_read or
// memory_write_enable) stays high every cycle. A cycle in which mem_ready=1
// completes the access; the FSM leaves MEM on that clock edge, so the strobe
// is low from the following cycle.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int PC_STEP = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic [3:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic [1:0]  alu_op,
   output logic        alu_src,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        reg_write_enable,
   output logic        memory_write_enable,
   output logic        memory_read,
   output logic        halted,
   output logic [2:0]  state
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [15:0] instr_retired,
   output logic [15:0] cycle_count
`endif
);

   // PC_STEP is applied by the datapath PC adder; it only has to be sane here
   if (PC_STEP < 1) begin : g_bad_pc_step
      $error("cpu_sequencer: PC_STEP must be positive");
   end

   state_t     state_q, state_d;
   logic [3:0] op_q;
   logic [3:0] op_sel;
   state_t     after_retire;
   logic       is_lw, is_sw, is_rtype, is_beq, is_bne, is_jmp, is_halt, is_nop;

   // DECODE classifies the live IR opcode; later states use the latched copy
   assign op_sel = (state_q == S_DECODE) ? opcode : op_q;

   seq_decode u_decode (
      .opcode   (op_sel),
      .is_lw    (is_lw),
      .is_sw    (is_sw),
      .is_rtype (is_rtype),
      .is_beq   (is_beq),
      .is_bne   (is_bne),
      .is_jmp   (is_jmp),
      .is_halt  (is_halt),
      .is_nop   (is_nop)
   );

   // a retiring instruction continues to FETCH only while run is held
   assign after_retire = run ? S_FETCH : S_IDLE;
   assign state        = state_q;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // capture the opcode while the IR is being decoded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  op_q <= 4'h0;
      else if (state_q == S_DECODE) op_q <= opcode;
   end

   // next-state and Moore output decode
   always_comb begin
      state_d             = state_q;
      ir_write            = 1'b0;
      pc_write            = 1'b0;
      pc_src              = PC_INC;
      alu_op              = ALU_FUNC;
      alu_src             = 1'b0;
      reg_dst             = 1'b0;
      mem_to_reg          = 1'b0;
      reg_write_enable    = 1'b0;
      memory_write_enable = 1'b0;
      memory_read         = 1'b0;
      halted              = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_INC;
            state_d  = S_DECODE;
         end
         S_DECODE: begin
            if (is_halt)     state_d = S_HALT;
            else if (is_nop) state_d = after_retire;
            else             state_d = S_EXECUTE;
         end
         S_EXECUTE: begin
            if (is_rtype) begin
               alu_op  = ALU_FUNC;
               alu_src = 1'b0;
               reg_dst = 1'b1;
               state_d = S_WRITEBACK;
            end else if (is_lw || is_sw) begin
               alu_op  = ALU_ADD;
               alu_src = 1'b1;
               state_d = S_MEM;
            end else if (is_beq || is_bne) begin
               alu_op = ALU_SUB;
               // BEQ takes the branch on zero, BNE on non-zero
               if (is_beq == zero) begin
                  pc_write = 1'b1;
                  pc_src   = PC_BRANCH;
               end
               state_d = after_retire;
            end else begin
               pc_write = is_jmp;
               pc_src   = is_jmp ? PC_JUMP : PC_INC;
               state_d  = after_retire;
            end
         end
         S_MEM: begin
            memory_read         = is_lw;
            memory_write_enable = is_sw;
            if (mem_ready) state_d = is_lw ? S_WRITEBACK : after_retire;
         end
         S_WRITEBACK: begin
            reg_write_enable = 1'b1;
            mem_to_reg       = is_lw;
            reg_dst          = is_rtype;
            state_d          = after_retire;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef SEQ_PERF_CNT_EN
   logic retire;

   // an instruction retires on the edge that ends its final cycle
   assign retire = (state_q == S_DECODE && is_nop) ||
                   (state_q == S_EXECUTE && (is_beq || is_bne || is_jmp)) ||
                   (state_q == S_MEM && is_sw && mem_ready) ||
                   (state_q == S_WRITEBACK);

   // retirement and active-cycle counters, wrapping naturally at 16 bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_retired <= 16'd0;
         cycle_count   <= 16'd0;
      end else begin
         if (retire) instr_retired <= instr_retired + 16'd1;
         if (state_q != S_IDLE && state_q != S_HALT) cycle_count <= cycle_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer. Per-instruction behaviour is compared
// against a reference model that predicts cycle counts and strobe totals from
// the opcode map. Define SEQ_PERF_CNT_EN to also cover the perf counters.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [3:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        ir_write, pc_write, alu_src, reg_dst, mem_to_reg;
  logic        reg_write_enable, memory_write_enable, memory_read, halted;
  logic [1:0]  pc_src, alu_op;
  logic [2:0]  state;
`ifdef SEQ_PERF_CNT_EN
  logic [15:0] instr_retired, cycle_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // per-instruction observation record
  localparam int F_CYC = 0, F_IR = 1, F_PCW = 2, F_PCSRC = 3, F_RD = 4, F_WR = 5;
  localparam int F_RW = 6, F_M2R = 7, F_RDST = 8, F_ALU = 9, F_EXCL = 10, F_TMO = 11;
  localparam int NF = 12;
  typedef int stats_t [0:NF-1];
  string f_name [0:NF-1] = '{"cycles", "ir_write_cnt", "pc_write_extra", "pc_src_extra",
                             "mem_read_cnt", "mem_write_cnt", "reg_write_cnt", "mem_to_reg",
                             "reg_dst", "alu_op_or", "strobe_overlap", "timeout"};

  logic [12:0] all_out;
  assign all_out = {ir_write, pc_write, pc_src, alu_op, alu_src, reg_dst, mem_to_reg,
                    reg_write_enable, memory_write_enable, memory_read, halted};

  cpu_sequencer #(.PC_STEP(2)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .run                 (run),
    .opcode              (opcode),
    .zero                (zero),
    .mem_ready           (mem_ready),
    .ir_write            (ir_write),
    .pc_write            (pc_write),
    .pc_src              (pc_src),
    .alu_op              (alu_op),
    .alu_src             (alu_src),
    .reg_dst             (reg_dst),
    .mem_to_reg          (mem_to_reg),
    .reg_write_enable    (reg_write_enable),
    .memory_write_enable (memory_write_enable),
    .memory_read         (memory_read),
    .halted              (halted),
    .state               (state)
`ifdef SEQ_PERF_CNT_EN
    ,
    .instr_retired       (instr_retired),
    .cycle_count         (cycle_count)
`endif
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // reference model: expected totals for one instruction, FETCH through the
  // cycle before the next FETCH, from the opcode map and cycle-count rules
  function automatic stats_t model_instr(input int op, input int z, input int stalls);
    stats_t e;
    e = '{default: 0};
    e[F_IR] = 1;
    if (op == 0) begin
      e[F_CYC] = 5 + stalls; e[F_RD] = stalls + 1; e[F_RW] = 1; e[F_M2R] = 1; e[F_ALU] = 2;
    end else if (op == 1) begin
      e[F_CYC] = 4 + stalls; e[F_WR] = stalls + 1; e[F_ALU] = 2;
    end else if (op >= 2 && op <= 9) begin
      e[F_CYC] = 4; e[F_RW] = 1; e[F_RDST] = 1;
    end else if (op == 11 || op == 12) begin
      e[F_CYC] = 3; e[F_ALU] = 1;
      if ((op == 11 && z == 1) || (op == 12 && z == 0)) begin
        e[F_PCW] = 1; e[F_PCSRC] = 1;
      end
    end else if (op == 13) begin
      e[F_CYC] = 3; e[F_PCW] = 1; e[F_PCSRC] = 2;
    end else begin
      e[F_CYC] = 2;
    end
    return e;
  endfunction

  // driver: runs one instruction starting at a FETCH cycle, answering memory
  // strobes with mem_ready after 'stalls' wait cycles, until the next FETCH
  task automatic run_instr(input logic [3:0] op, input logic z, input int stalls,
                           output stats_t s);
    int seen;
    s = '{default: 0};
    seen = 0;
    opcode = op;
    zero = z;
    mem_ready = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (ir_write) s[F_IR]++;
      if (pc_write && !ir_write) begin s[F_PCW]++; s[F_PCSRC] = int'(pc_src); end
      if (memory_read) s[F_RD]++;
      if (memory_write_enable) s[F_WR]++;
      if (reg_write_enable) begin
        s[F_RW]++; s[F_M2R] = int'(mem_to_reg); s[F_RDST] = int'(reg_dst);
      end
      s[F_ALU] = s[F_ALU] | int'(alu_op);
      if ($countones({ir_write, reg_write_enable, memory_write_enable}) > 1) s[F_EXCL]++;
      if (memory_read || memory_write_enable) begin
        mem_ready = (seen == stalls);
        seen++;
      end else begin
        mem_ready = 1'b0;
      end
      s[F_CYC]++;
      tick();
      if (ir_write) return;
    end
    s[F_TMO] = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; run = 1'b0; opcode = 4'h0; zero = 1'b0; mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d required %0d", state, S_IDLE); end
    n_checks++;
    if (all_out !== 13'h0) begin n_fail++; $display("FAIL reset_outputs: got %h required 0", all_out); end
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    n_checks++;
    if (state !== S_IDLE) begin n_fail++; $display("FAIL idle_without_run: got %0d required %0d", state, S_IDLE); end
    run = 1'b1;
    tick();
    n_checks++;
    if (state !== S_FETCH || ir_write !== 1'b1 || pc_write !== 1'b1 || pc_src !== 2'b00) begin
      n_fail++; $display("FAIL first_fetch: got state=%0d ir_write=%b pc_write=%b pc_src=%b required FETCH,1,1,00",
                         state, ir_write, pc_write, pc_src);
    end
  endtask

  task automatic test_rtype_sequence();
    state_t exp_s [0:4] = '{S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_FETCH};
    opcode = 4'b0010; zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (state !== exp_s[i]) begin n_fail++; $display("FAIL rtype_state cycle %0d: got %0d required %0d", i + 1, state, exp_s[i]); end
      n_checks++;
      if (reg_write_enable !== (i == 3)) begin n_fail++; $display("FAIL rtype_reg_write cycle %0d: got %b required %b", i + 1, reg_write_enable, (i == 3)); end
      n_checks++;
      if (alu_op !== 2'b00) begin n_fail++; $display("FAIL rtype_alu_op cycle %0d: got %b required 00", i + 1, alu_op); end
      if (i == 2) begin
        n_checks++;
        if (reg_dst !== 1'b1 || alu_src !== 1'b0) begin n_fail++; $display("FAIL rtype_exec_mux: got reg_dst=%b alu_src=%b required 1,0", reg_dst, alu_src); end
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_lw_stall();
    stats_t s;
    run_instr(4'h0, 1'b0, 3, s);
    n_checks++;
    if (s[F_CYC] !== 8) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d required 8", s[F_CYC]); end
    n_checks++;
    if (s[F_RD] !== 4) begin n_fail++; $display("FAIL lw_stall_read_cycles: got %0d required 4", s[F_RD]); end
    n_checks++;
    if (s[F_RW] !== 1 || s[F_M2R] !== 1 || s[F_RDST] !== 0) begin
      n_fail++; $display("FAIL lw_writeback: got rw=%0d m2r=%0d rdst=%0d required 1,1,0", s[F_RW], s[F_M2R], s[F_RDST]);
    end
  endtask

  task automatic test_branches();
    stats_t s;
    logic [3:0] ops [0:3] = '{4'hB, 4'hB, 4'hC, 4'hC};
    logic       zs  [0:3] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int         tk  [0:3] = '{1, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      run_instr(ops[i], zs[i], 0, s);
      n_checks++;
      if (s[F_PCW] !== tk[i]) begin n_fail++; $display("FAIL branch_pc_write op=%h zero=%b: got %0d required %0d", ops[i], zs[i], s[F_PCW], tk[i]); end
      n_checks++;
      if (s[F_PCSRC] !== tk[i] || s[F_ALU] !== 1 || s[F_CYC] !== 3) begin
        n_fail++; $display("FAIL branch_exec op=%h zero=%b: got pc_src=%0d alu_op=%0d cycles=%0d required %0d,1,3",
                           ops[i], zs[i], s[F_PCSRC], s[F_ALU], s[F_CYC], tk[i]);
      end
    end
  endtask

  task automatic test_random();
    stats_t s, e;
    int op, z, st;
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 14);
      z  = $urandom_range(0, 1);
      st = $urandom_range(0, 3);
      e = model_instr(op, z, st);
      run_instr(4'(op), 1'(z), st, s);
      for (int k = 0; k < NF; k++) begin
        n_checks++;
        if (s[k] !== e[k]) begin
          n_fail++; $display("FAIL random_%s op=%h zero=%0d stalls=%0d: got %0d required %0d", f_name[k], op, z, st, s[k], e[k]);
        end
      end
      if (s[F_TMO] != 0) begin
        $display("FAIL random_sync: got lost fetch required fetch boundary");
        $fatal(1, "lost instruction boundary");
      end
    end
  endtask

  task automatic test_run_drop();
    int rw, cyc;
    opcode = 4'h0; zero = 1'b0; mem_ready = 1'b0;
    tick();
    run = 1'b0;
    rw = 0;
    cyc = 0;
    while (state !== S_IDLE && cyc < 30) begin
      if (reg_write_enable) rw++;
      mem_ready = memory_read;
      cyc++;
      tick();
    end
    n_checks++;
    if (state !== S_IDLE || rw !== 1) begin n_fail++; $display("FAIL run_drop_retire: got state=%0d reg_writes=%0d required IDLE,1", state, rw); end
    n_checks++;
    if (cyc !== 4) begin n_fail++; $display("FAIL run_drop_cycles: got %0d required 4", cyc); end
    tick(); tick();
    n_checks++;
    if (state !== S_IDLE || all_out !== 13'h0) begin n_fail++; $display("FAIL run_drop_idle: got state=%0d outs=%h required IDLE,0", state, all_out); end
    run = 1'b1;
    tick();
    n_checks++;
    if (state !== S_FETCH) begin n_fail++; $display("FAIL run_resume: got %0d required %0d", state, S_FETCH); end
  endtask

  task automatic test_halt();
    int bad;
    opcode = 4'hF;
    tick();
    n_checks++;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_decode: got %b required 0", halted); end
    tick();
    n_checks++;
    if (halted !== 1'b1 || state !== S_HALT) begin n_fail++; $display("FAIL halt_enter: got halted=%b state=%0d required 1,%0d", halted, state, S_HALT); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      opcode = 4'($urandom_range(0, 15));
      tick();
      if (all_out !== 13'h1) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL halt_sticky: got %0d bad cycles required 0", bad); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (halted !== 1'b0 || state !== S_IDLE) begin n_fail++; $display("FAIL halt_reset: got halted=%b state=%0d required 0,IDLE", halted, state); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (state !== S_FETCH) begin n_fail++; $display("FAIL halt_reset_fetch: got %0d required %0d", state, S_FETCH); end
  endtask

  task automatic test_reset_mid_mem();
    opcode = 4'h1; mem_ready = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (memory_write_enable !== 1'b1 || state !== S_MEM) begin
      n_fail++; $display("FAIL sw_mem_entry: got wr=%b state=%0d required 1,%0d", memory_write_enable, state, S_MEM);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (memory_write_enable !== 1'b0 || state !== S_IDLE || all_out !== 13'h0) begin
      n_fail++; $display("FAIL sw_async_reset: got wr=%b state=%0d outs=%h required 0,IDLE,0", memory_write_enable, state, all_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

`ifdef SEQ_PERF_CNT_EN
  task automatic test_perf_counters();
    run = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (instr_retired !== 16'd0 || cycle_count !== 16'd0) begin
      n_fail++; $display("FAIL perf_reset: got %0d,%0d required 0,0", instr_retired, cycle_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    opcode = 4'h2;
    mem_ready = 1'b1;
    run = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) tick();
    run = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (instr_retired !== 16'd3) begin n_fail++; $display("FAIL perf_instr_retired: got %0d required 3", instr_retired); end
    n_checks++;
    if (cycle_count !== 16'd12) begin n_fail++; $display("FAIL perf_cycle_count: got %0d required 12", cycle_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_rtype_sequence();
    test_lw_stall();
    test_branches();
    test_random();
    test_run_drop();
    test_halt();
    test_reset_mid_mem();
`ifdef SEQ_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
